// File: rtl/score_counter.sv
// score_counter: BCD score accumulator with run/over FSM, level, milestone and high score.
//
// Counts rising edges of the divider's score tick while a run is active,
// freezes the score at game over and derives a difficulty level.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   gameon       play state active (synchronous to clk)
//   score_tick   square-wave score tick (synchronous to clk)
//   score_bcd    current score, 4 BCD digits, [15:12] = thousands
//   hiscore_bcd  session high score, BCD (0 when high score is not built)
//   level        difficulty level 0..7
//   running      high while in RUN
//   milestone    one-cycle pulse when the score reaches a milestone boundary
//   new_record   one-cycle pulse when the high score is replaced
//
// Build option: define SCORE_HISCORE_EN to build the high-score register,
// compare and new_record pulse; otherwise those outputs are tied to zero.
module score_counter #(
    parameter logic [15:0] SCORE_MAX           = 16'h9999,
    parameter int          LEVEL_STEP_HUNDREDS = 1,
    parameter int          MILESTONE_HUNDREDS  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gameon,
    input  logic        score_tick,
    output logic [15:0] score_bcd,
    output logic [15:0] hiscore_bcd,
    output logic [2:0]  level,
    output logic        running,
    output logic        milestone,
    output logic        new_record
);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t      state, state_next;
    logic        tick_q, gameon_q;
    logic [15:0] score_next;
    logic [2:0]  level_next;
    logic        milestone_next;
    logic        rise, inc, bump;

    // Ripple a +1 through the four BCD digits; a 9 rolls to 0 and carries on.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Whole hundreds of points: 10 * thousands digit + hundreds digit.
    function automatic logic [6:0] hundreds(input logic [15:0] v);
        return 7'(v[15:12]) * 7'd10 + 7'(v[11:8]);
    endfunction

    function automatic logic [2:0] level_of(input logic [15:0] v);
        logic [6:0] q;
        q = hundreds(v) / 7'(LEVEL_STEP_HUNDREDS);
        return (q > 7'd7) ? 3'd7 : q[2:0];
    endfunction

    assign rise    = gameon & ~gameon_q;
    assign inc     = score_tick & ~tick_q & (state == RUN) & gameon;
    // Saturated scores take no increment, which also suppresses the milestone.
    assign bump    = inc && (score_bcd != SCORE_MAX);
    assign running = (state == RUN);

    always_comb begin
        state_next = state;
        score_next = score_bcd;
        case (state)
            IDLE, OVER: begin
                if (rise) begin
                    state_next = RUN;
                    score_next = '0;
                end
            end
            RUN: begin
                if (!gameon) state_next = OVER;
                else if (bump) score_next = bcd_inc(score_bcd);
            end
            default: state_next = IDLE;
        endcase
    end

    assign level_next     = level_of(score_next);
    assign milestone_next = bump && (score_next[7:0] == 8'h00) && (hundreds(score_next) != 7'd0)
                            && (hundreds(score_next) % 7'(MILESTONE_HUNDREDS) == 7'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_q    <= 1'b0;
            gameon_q  <= 1'b0;
            score_bcd <= '0;
            level     <= '0;
            milestone <= 1'b0;
        end else begin
            state     <= state_next;
            tick_q    <= score_tick;
            gameon_q  <= gameon;
            score_bcd <= score_next;
            level     <= level_next;
            milestone <= milestone_next;
        end
    end

`ifdef SCORE_HISCORE_EN
    logic [15:0] hiscore_q;
    logic        new_record_q;
    logic        finish;

    assign finish = (state == RUN) && !gameon;

    // Valid BCD orders the same as plain binary, so a direct compare is digit-wise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hiscore_q    <= '0;
            new_record_q <= 1'b0;
        end else begin
            new_record_q <= finish && (score_bcd > hiscore_q);
            if (finish && (score_bcd > hiscore_q)) hiscore_q <= score_bcd;
        end
    end

    assign hiscore_bcd = hiscore_q;
    assign new_record  = new_record_q;
`else
    assign hiscore_bcd = 16'h0000;
    assign new_record  = 1'b0;
`endif

endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed table and sequence checks for score_counter.
module tb_score_counter;

`ifdef SCORE_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif
    localparam int LSTEP = 1;
    localparam int MSTEP = 1;

    logic        clk = 1'b0;
    logic        rst_n, gameon, score_tick;
    logic [15:0] score_bcd, hiscore_bcd;
    logic [2:0]  level;
    logic        running, milestone, new_record;

    int          errors = 0;
    int          checks = 0;
    int          changes = 0;
    logic [15:0] prev_score = '0;
    logic [15:0] model = '0;

    score_counter dut (
        .clk(clk), .rst_n(rst_n), .gameon(gameon), .score_tick(score_tick),
        .score_bcd(score_bcd), .hiscore_bcd(hiscore_bcd), .level(level),
        .running(running), .milestone(milestone), .new_record(new_record)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (score_bcd !== prev_score) changes++;
        prev_score = score_bcd;
    end

    typedef struct packed {
        logic        g;
        logic        t;
        logic [15:0] sc;
        logic        run;
        logic        nr;
        logic [15:0] hi;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [15:0] hv(input logic [15:0] v);
        return HI_EN ? v : 16'h0000;
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    function automatic int exp_level(input int n);
        int q;
        q = (n / 100) / LSTEP;
        return (q > 7) ? 7 : q;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One tick rising edge, high for one cycle, then low for one cycle.
    task automatic tick();
        int  p, n;
        logic ms;
        p = bcd2int(model);
        n = (p == 9999) ? p : p + 1;
        ms = (n != p) && (n % 100 == 0) && (n >= 100) && ((n / 100) % MSTEP == 0);
        score_tick = 1'b1;
        @(negedge clk);
        model = int2bcd(n);
        chk("tick_score", score_bcd, model);
        chk("tick_level", 16'(level), 16'(exp_level(n)));
        chk("tick_milestone", 16'(milestone), 16'(ms));
        score_tick = 1'b0;
        @(negedge clk);
        chk("milestone_clear", 16'(milestone), 16'h0);
    endtask

    task automatic start_run();
        gameon = 1'b1;
        @(negedge clk);
        model = '0;
        chk("start_score", score_bcd, 16'h0);
        chk("start_running", 16'(running), 16'h1);
    endtask

    // Drop gameon in the same cycle as a tick rising edge.
    task automatic game_over(input logic [15:0] exp_hi, input logic exp_nr);
        gameon = 1'b0;
        score_tick = 1'b1;
        @(negedge clk);
        chk("over_score", score_bcd, model);
        chk("over_running", 16'(running), 16'h0);
        chk("over_new_record", 16'(new_record), 16'(exp_nr));
        chk("over_hiscore", hiscore_bcd, exp_hi);
        score_tick = 1'b0;
        @(negedge clk);
        chk("over_new_record_clear", 16'(new_record), 16'h0);
        chk("over_hiscore_hold", hiscore_bcd, exp_hi);
        chk("over_score_hold", score_bcd, model);
    endtask

    task automatic sync_reset();
        gameon = 1'b0;
        score_tick = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_hiscore", hiscore_bcd, 16'h0);
        chk("reset_score", score_bcd, 16'h0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 16'h0000, 1'b1, 1'b0,  hv(16'h0)};
        tbl[1]  = '{1'b1, 1'b1, 16'h0000, 1'b1, 1'b0,  hv(16'h0)};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0,  hv(16'h0)};
        tbl[3]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b0,  hv(16'h0)};
        tbl[4]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b0,  hv(16'h0)};
        tbl[5]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b0,  hv(16'h0)};
        tbl[6]  = '{1'b1, 1'b0, 16'h0001, 1'b1, 1'b0,  hv(16'h0)};
        tbl[7]  = '{1'b1, 1'b1, 16'h0002, 1'b1, 1'b0,  hv(16'h0)};
        tbl[8]  = '{1'b1, 1'b0, 16'h0002, 1'b1, 1'b0,  hv(16'h0)};
        tbl[9]  = '{1'b0, 1'b1, 16'h0002, 1'b0, HI_EN, hv(16'h2)};
        tbl[10] = '{1'b0, 1'b0, 16'h0002, 1'b0, 1'b0,  hv(16'h2)};
        tbl[11] = '{1'b0, 1'b1, 16'h0002, 1'b0, 1'b0,  hv(16'h2)};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0,  hv(16'h2)};
        tbl[13] = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b0,  hv(16'h2)};
        tbl[14] = '{1'b0, 1'b0, 16'h0001, 1'b0, 1'b0,  hv(16'h2)};
        tbl[15] = '{1'b1, 1'b1, 16'h0000, 1'b1, 1'b0,  hv(16'h2)};

        rst_n = 1'b0;
        gameon = 1'b0;
        score_tick = 1'b0;
        @(negedge clk);
        chk("rst_score", score_bcd, 16'h0);
        chk("rst_hiscore", hiscore_bcd, 16'h0);
        chk("rst_level", 16'(level), 16'h0);
        chk("rst_running", 16'(running), 16'h0);
        chk("rst_milestone", 16'(milestone), 16'h0);
        chk("rst_new_record", 16'(new_record), 16'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            gameon = tbl[i].g;
            score_tick = tbl[i].t;
            @(negedge clk);
            chk($sformatf("vec%0d_score", i), score_bcd, tbl[i].sc);
            chk($sformatf("vec%0d_running", i), 16'(running), 16'(tbl[i].run));
            chk($sformatf("vec%0d_new_record", i), 16'(new_record), 16'(tbl[i].nr));
            chk($sformatf("vec%0d_hiscore", i), hiscore_bcd, tbl[i].hi);
            chk($sformatf("vec%0d_level", i), 16'(level), 16'h0);
            chk($sformatf("vec%0d_milestone", i), 16'(milestone), 16'h0);
        end

        // Asynchronous reset mid-run, with gameon still high across release.
        score_tick = 1'b0;
        model = '0;
        @(negedge clk);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_score", score_bcd, 16'h0);
        chk("async_hiscore", hiscore_bcd, 16'h0);
        chk("async_level", 16'(level), 16'h0);
        chk("async_running", 16'(running), 16'h0);
        chk("async_milestone", 16'(milestone), 16'h0);
        chk("async_new_record", 16'(new_record), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerun_running", 16'(running), 16'h1);
        chk("rerun_score", score_bcd, 16'h0);
        model = '0;

        changes = 0;
        for (int i = 0; i < 12; i++) tick();
        chk("twelve_score", score_bcd, 16'h0012);
        chk("twelve_level", 16'(level), 16'h0);
        chk("twelve_running", 16'(running), 16'h1);
        chk("twelve_changes", 16'(changes), 16'd12);

        while (model != 16'h0099) tick();
        tick();
        chk("hundred_score", score_bcd, 16'h0100);
        chk("hundred_level", 16'(level), 16'h1);

        while (model != 16'h9999) tick();
        for (int i = 0; i < 3; i++) tick();
        chk("sat_score", score_bcd, 16'h9999);
        chk("sat_level", 16'(level), 16'h7);
        game_over(hv(16'h9999), HI_EN);

        sync_reset();
        start_run();
        while (model != 16'h0042) tick();
        game_over(hv(16'h0042), HI_EN);
        start_run();
        while (model != 16'h0030) tick();
        game_over(hv(16'h0042), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_counter.md
# score_counter

Downstream consumer of the 9 Hz score tick from the clock divider: edge-detects the tick, accumulates a 4-digit BCD score while a run is active, and freezes the score at game over. Tracks a session high score and derives a 3-bit difficulty level for the obstacle logic. Outputs feed the OLED renderer's digit drawing and the obstacle speed selection.

## Interface
- SCORE_MAX, 16'h9999, BCD saturation value of the score
- LEVEL_STEP_HUNDREDS, 1, level increments once per this many hundreds of points (1..9)
- MILESTONE_HUNDREDS, 1, milestone pulse every this many hundreds of points (1..9)

- clk  in  1  system clock, 27 MHz
- rst_n  in  1  asynchronous active-low reset
- gameon  in  1  high while the play state is active; synchronous to clk
- score_tick  in  1  50 % duty square wave from the divider; synchronous to clk
- score_bcd  out  16  current score, 4 BCD digits, [15:12] = thousands
- hiscore_bcd  out  16  session high score, BCD
- level  out  3  difficulty level 0..7
- running  out  1  high in RUN state
- milestone  out  1  one-cycle pulse on crossing a milestone boundary
- new_record  out  1  one-cycle pulse when the high score is replaced

## Operation
- States: IDLE (after reset), RUN, OVER. Encoding is free; `running` is 1 only in RUN.
- Edge detect: `tick_q` samples `score_tick` every cycle; `inc = score_tick & ~tick_q & (state==RUN) & gameon`.
- `gameon` rise (`gameon & ~gameon_q`) from IDLE or OVER: score cleared to 0, level cleared to 0, go to RUN. No increment on that cycle, even if `inc` would be true.
- RUN, `inc`: score += 1 in BCD. Digit carry: 9 -> 0 with a carry into the next digit. At SCORE_MAX the score holds; no wrap to 0.
- RUN, `gameon` low: go to OVER. A tick edge in the same cycle is ignored. If score > hiscore (BCD compare, most significant digit first), hiscore <= score and new_record pulses.
- OVER: score and level hold until the next `gameon` rise.
- Level: H = 10*thousands + hundreds digit. level = min(H / LEVEL_STEP_HUNDREDS, 7). Level is registered and updated on the same edge as the score.
- Milestone: pulses when an increment makes the tens and units digits 00 and H is a nonzero multiple of MILESTONE_HUNDREDS. It does not pulse at saturation or on clear.

## Timing
- Reset values: score_bcd = 0, hiscore_bcd = 0, level = 0, running = 0, milestone = 0, new_record = 0, tick_q = 0, gameon_q = 0, state = IDLE.
- Score latency: score_bcd updates on the clk edge at which score_tick = 1 is first sampled after a 0. Exactly one increment per tick rising edge, regardless of tick width.
- running rises on the edge that samples the gameon rise, and falls on the edge that samples gameon = 0.
- new_record is asserted for the cycle following the RUN->OVER edge, together with the hiscore_bcd update.
- milestone is registered and coincides with the score_bcd value that reached the boundary.
- rst_n assertion mid-run clears everything immediately, including hiscore. After rst_n deasserts, a gameon that is already high is treated as a rise on the first sampled cycle, because gameon_q resets to 0.

## Configuration
- SCORE_HISCORE_EN defined: high-score register, compare and new_record are built as described above.
- SCORE_HISCORE_EN undefined: no high-score logic. hiscore_bcd is tied to 16'h0000 and new_record to 0. All other behaviour is unchanged.

## Test plan
- Reset, then gameon = 1, then 12 tick rising edges -> score_bcd = 16'h0012, level = 0, running = 1, and exactly 12 single-cycle increments.
- Preload via ticks to 16'h0099, then one tick -> score_bcd = 16'h0100, milestone pulses for 1 cycle, level = 1.
- Drive to 16'h9999, then 3 more ticks -> score stays 16'h9999, level = 7, no milestone.
- Score 16'h0042, then drop gameon in the same cycle as a tick edge -> score stays 16'h0042, OVER state, hiscore_bcd = 16'h0042, new_record pulses. A second run ending at 16'h0030 -> hiscore unchanged, no pulse.
- gameon rise coincident with a tick edge from OVER -> score = 0, no increment. Then assert rst_n = 0 mid-run -> all outputs 0 asynchronously.
- Build without SCORE_HISCORE_EN and repeat the game-over scenario -> hiscore_bcd = 0, new_record never asserted.
